elevator_controller: RTL and testbench
======================================

// Module: elevator_controller
// PURPOSE
//  Three-floor (0..2) lift controller with a SCAN policy. Latches hall calls and cab requests, moves
//  one floor per TRAVEL_CYCLES, and dwells DOOR_CYCLES at each served floor.
//  Drives a floor 7-segment digit, up/down arrows and status outputs. Top of the lift subsystem.
// PARAMETERS
//  TRAVEL_CYCLES  4  clocks to travel one floor (>=1)
//  DOOR_CYCLES    3  clocks the door stays open at a served floor (>=1)
// PORTS
//  clk                in   1  single system clock, rising edge
//  rst_n              in   1  reset; synchronous, active-low
//  external_calls     in   3  hall call per floor, bit i = floor i, level-sampled each clk
//  internal_requests  in   3  cab request per floor, bit i = floor i, level-sampled each clk
//  seg_a_to_g         out  7  floor digit, bit6=a .. bit0=g, active-high
//  arrow              out  2  arrow[1]=up lamp, arrow[0]=down lamp
//  current_floor      out  3  floor number 0..2 (values 3..7 never driven)
//  direction          out  2  00 idle/door, 01 up, 10 down (11 never driven)
//  elevator_moving    out  1  1 while in MOVE_UP/MOVE_DOWN
// BEHAVIOUR
//  - Reset: state IDLE, current_floor=0, pending=000, last_dir=UP, timers=0; direction=00,
//    arrow=00, elevator_moving=0, seg_a_to_g=7'b1111110.
//  - Reset mid-operation: same values on the next edge; all pending requests are discarded.
//  - Request latch: each edge, pending <= (pending | external_calls | internal_requests) & ~clr.
//    clr is the current-floor bit when serving. Clear wins over a same-cycle set for that floor.
//  - FSM decisions use registered pending. A request asserted before edge k sets pending at k;
//    the FSM leaves IDLE at edge k+1.
//  - IDLE priority: pending[floor] -> DOOR_OPEN; else pending above -> MOVE_UP; else pending below
//    -> MOVE_DOWN; else stay IDLE.
//  - MOVE_UP/MOVE_DOWN: timer counts TRAVEL_CYCLES. On the terminal count, floor +/-1 and the
//    timer clears.
//  - Arrival: pending[new floor] -> DOOR_OPEN; else pending ahead -> continue; else pending behind
//    -> reverse; else IDLE.
//  - No move above floor 2 or below floor 0. At floor 2, "ahead" for UP is empty; at floor 0,
//    "ahead" for DOWN is empty.
//  - DOOR_OPEN: the pending bit for the current floor is cleared every cycle in this state (new
//    calls for this floor are absorbed). Timer counts DOOR_CYCLES, then: pending ahead in last_dir
//    -> move that way; else pending opposite -> move opposite; else IDLE.
//  - last_dir updates on every entry to MOVE_UP/MOVE_DOWN.
//  - Outputs: current_floor, state registered. direction/elevator_moving decoded from state.
//    arrow = {direction==01, direction==10}.
//  - seg_a_to_g is combinational from current_floor: 0=1111110, 1=0110000, 2=1101101,
//    others=0000000.
// CONFIGURATION
//  - ELEV_SEG_ACTIVE_LOW_EN defined: seg_a_to_g is bitwise inverted (common-anode), reset value
//    7'b0000001.
//  - Undefined (default): active-high as above. No other output changes.
// STRUCTURE
//  - Package elevator_pkg: state enum {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN}; DIR_IDLE=2'b00,
//    DIR_UP=2'b01, DIR_DOWN=2'b10; SEG_0/1/2/BLANK constants; floor constants 0..2.
//  - Sub-module elevator_seg7_dec: 3-bit floor -> 7-bit segment pattern, honours the macro.
//  - Request latch, timer and FSM stay in the top.
// TESTING (defaults TRAVEL_CYCLES=4, DOOR_CYCLES=3)
//  - Reset held 1 clk -> floor 0, seg 1111110, direction 00, arrow 00, moving 0, pending 000.
//  - external_calls[2] pulsed 2 clks at floor 0 -> moving=1, direction 01, arrow 10.
//    floor 1 after 4 move clks, floor 2 after 8; door 3 clks; IDLE, seg 1101101.
//  - internal_requests[0] at floor 2 -> direction 10; floor 1 then 0 at 4-clk steps; door 3 clks;
//    IDLE, pending 000.
//  - From floor 0, external_calls[1] and internal_requests[2] together -> stop at 1 (door 3 clks),
//    continue up to 2, door, IDLE.
//  - Request for current floor while IDLE -> no movement, moving stays 0, DOOR_OPEN 3 clks,
//    bit cleared.
//  - rst_n low during MOVE_UP between floors -> next edge floor 0, IDLE, pending 000, outputs at
//    reset values.

Source files
------------

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared states, direction codes, floor numbers and segment patterns.
package elevator_pkg;
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] FLOOR_0 = 2'd0;
  localparam logic [1:0] FLOOR_1 = 2'd1;
  localparam logic [1:0] FLOOR_2 = 2'd2;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  // Floors strictly above / strictly below f, as a 3-bit floor mask.
  function automatic logic [2:0] above_mask(input logic [1:0] f);
    return 3'b110 << f;
  endfunction
  function automatic logic [2:0] below_mask(input logic [1:0] f);
    return ~(3'b111 << f);
  endfunction
endpackage

// File: rtl/elevator_if.sv
// elevator_if: request inputs and display/status outputs of the lift controller.
//   master: drives external_calls/internal_requests, observes the status outputs
//   slave : the controller side
interface elevator_if;
  logic [2:0] external_calls;
  logic [2:0] internal_requests;
  logic [6:0] seg_a_to_g;
  logic [1:0] arrow;
  logic [2:0] current_floor;
  logic [1:0] direction;
  logic       elevator_moving;
  modport master (
    output external_calls, internal_requests,
    input  seg_a_to_g, arrow, current_floor, direction, elevator_moving
  );
  modport slave (
    input  external_calls, internal_requests,
    output seg_a_to_g, arrow, current_floor, direction, elevator_moving
  );
endinterface

// File: rtl/elevator_seg7_dec.sv
// elevator_seg7_dec: floor number -> 7-segment digit (bit6=a .. bit0=g).
//   floor in  3  floor number, 3..7 blank the digit
//   seg   out 7  active-high, or inverted for common-anode when ELEV_SEG_ACTIVE_LOW_EN is defined
module elevator_seg7_dec
  import elevator_pkg::*;
(
  input  logic [2:0] floor,
  output logic [6:0] seg
);
  logic [6:0] pat;
  assign pat = floor == 3'd0 ? SEG_0 :
               floor == 3'd1 ? SEG_1 :
               floor == 3'd2 ? SEG_2 : SEG_BLANK;
`ifdef ELEV_SEG_ACTIVE_LOW_EN
  assign seg = ~pat;
`else
  assign seg = pat;
`endif
endmodule

// File: rtl/elevator_controller.sv
// elevator_controller: three-floor SCAN lift controller with request latch, travel/door timer and display.
//   clk    in  system clock, rising edge
//   rst_n  in  synchronous active-low reset
//   bus    elevator_if.slave: external_calls/internal_requests in; seg_a_to_g, arrow,
//          current_floor, direction, elevator_moving out
//   Segment polarity is selected by ELEV_SEG_ACTIVE_LOW_EN in elevator_seg7_dec.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input logic      clk,
  input logic      rst_n,
  elevator_if.slave bus
);
  localparam int TMAX = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  state_t          state;
  logic [1:0]      floor;
  logic [2:0]      pending;
  logic [1:0]      last_dir;
  logic [TW-1:0]   timer;
  logic [2:0]      clr;
  logic [1:0]      nf;
  logic            up_here, dn_here, up_nf, dn_nf, fwd_here, back_here;
  // A served floor absorbs its own calls for the whole time the door is open.
  assign clr       = state == DOOR_OPEN ? 3'b001 << floor : 3'b000;
  assign up_here   = |(pending & above_mask(floor));
  assign dn_here   = |(pending & below_mask(floor));
  assign fwd_here  = last_dir == DIR_UP ? up_here : dn_here;
  assign back_here = last_dir == DIR_UP ? dn_here : up_here;
  // Floor reached at the end of the current travel leg and the demand seen from there.
  assign nf        = state == MOVE_UP ? floor + 2'd1 : floor - 2'd1;
  assign up_nf     = |(pending & above_mask(nf));
  assign dn_nf     = |(pending & below_mask(nf));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      floor    <= FLOOR_0;
      pending  <= 3'b000;
      last_dir <= DIR_UP;
      timer    <= '0;
    end else begin
      pending <= (pending | bus.external_calls | bus.internal_requests) & ~clr;
      case (state)
        IDLE: begin
          if (pending[floor]) state <= DOOR_OPEN;
          else if (up_here) begin
            state    <= MOVE_UP;
            last_dir <= DIR_UP;
          end else if (dn_here) begin
            state    <= MOVE_DOWN;
            last_dir <= DIR_DOWN;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (timer == TW'(TRAVEL_CYCLES - 1)) begin
            timer <= '0;
            floor <= nf;
            if (pending[nf]) state <= DOOR_OPEN;
            else if (state == MOVE_UP ? up_nf : dn_nf) state <= state;
            else if (state == MOVE_UP ? dn_nf : up_nf) begin
              state    <= state == MOVE_UP ? MOVE_DOWN : MOVE_UP;
              last_dir <= state == MOVE_UP ? DIR_DOWN : DIR_UP;
            end else state <= IDLE;
          end else timer <= timer + 1'b1;
        end
        DOOR_OPEN: begin
          if (timer == TW'(DOOR_CYCLES - 1)) begin
            timer <= '0;
            if (fwd_here) state <= last_dir == DIR_UP ? MOVE_UP : MOVE_DOWN;
            else if (back_here) begin
              state    <= last_dir == DIR_UP ? MOVE_DOWN : MOVE_UP;
              last_dir <= last_dir == DIR_UP ? DIR_DOWN : DIR_UP;
            end else state <= IDLE;
          end else timer <= timer + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.current_floor   = {1'b0, floor};
  assign bus.direction       = state == MOVE_UP ? DIR_UP : state == MOVE_DOWN ? DIR_DOWN : DIR_IDLE;
  assign bus.elevator_moving = state == MOVE_UP || state == MOVE_DOWN;
  assign bus.arrow           = {bus.direction == DIR_UP, bus.direction == DIR_DOWN};
  elevator_seg7_dec u_seg (
    .floor (bus.current_floor),
    .seg   (bus.seg_a_to_g)
  );
endmodule

// File: tb/tb_elevator_controller.sv
// tb_elevator_controller: directed scenarios plus random requests against a behavioural lift model.
module tb_elevator_controller;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  elevator_if bus ();
  elevator_controller #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  int m_mode, m_floor, m_left;
  bit m_up;
  bit m_pend [3];
  int seg_tab [3] = '{7'h7E, 7'h30, 7'h6D};
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit pend_toward(input bit up);
    bit r = 0;
    for (int j = 0; j < 3; j++)
      if (m_pend[j] && (up ? j > m_floor : j < m_floor)) r = 1;
    return r;
  endfunction
  task automatic start_move(input bit up);
    m_mode = up ? M_UP : M_DOWN;
    m_up   = up;
    m_left = TRAVEL;
  endtask
  // Advance the model across one clock edge given the inputs present before it.
  task automatic model_edge(input bit rst, input bit [2:0] ext, input bit [2:0] inr);
    bit nx [3];
    for (int i = 0; i < 3; i++)
      nx[i] = (m_pend[i] || ext[i] || inr[i]) && !(m_mode == M_DOOR && i == m_floor);
    if (!rst) begin
      m_mode = M_IDLE; m_floor = 0; m_left = 0; m_up = 1;
      m_pend = '{0, 0, 0};
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (m_pend[m_floor]) begin m_mode = M_DOOR; m_left = DOOR; end
        else if (pend_toward(1)) start_move(1);
        else if (pend_toward(0)) start_move(0);
      end
      M_UP, M_DOWN: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += (m_mode == M_UP) ? 1 : -1;
          if (m_pend[m_floor]) begin m_mode = M_DOOR; m_left = DOOR; end
          else if (pend_toward(m_up)) m_left = TRAVEL;
          else if (pend_toward(!m_up)) start_move(!m_up);
          else m_mode = M_IDLE;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          if (pend_toward(m_up)) start_move(m_up);
          else if (pend_toward(!m_up)) start_move(!m_up);
          else m_mode = M_IDLE;
        end
      end
    endcase
    m_pend = nx;
  endtask
  task automatic check_all();
    int dir = m_mode == M_UP ? 1 : m_mode == M_DOWN ? 2 : 0;
    int seg = seg_tab[m_floor];
`ifdef ELEV_SEG_ACTIVE_LOW_EN
    seg = ~seg & 7'h7F;
`endif
    check("floor", int'(bus.current_floor), m_floor);
    check("direction", int'(bus.direction), dir);
    check("arrow", int'(bus.arrow), dir == 1 ? 2 : dir == 2 ? 1 : 0);
    check("moving", int'(bus.elevator_moving), int'(m_mode == M_UP || m_mode == M_DOWN));
    check("seg", int'(bus.seg_a_to_g), seg);
    check("pending", int'(dut.pending), {m_pend[2], m_pend[1], m_pend[0]});
  endtask
  task automatic cyc(input bit rst, input bit [2:0] ext, input bit [2:0] inr, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n = rst;
      bus.external_calls = ext;
      bus.internal_requests = inr;
      model_edge(rst, ext, inr);
      @(posedge clk);
      #1 check_all();
    end
  endtask
  initial begin
    bus.external_calls = 3'b000;
    bus.internal_requests = 3'b000;
    m_mode = M_IDLE; m_floor = 0; m_left = 0; m_up = 1;
    m_pend = '{0, 0, 0};
    cyc(0, 0, 0, 1);
`ifdef ELEV_SEG_ACTIVE_LOW_EN
    check("reset_seg", int'(bus.seg_a_to_g), 7'h01);
`else
    check("reset_seg", int'(bus.seg_a_to_g), 7'h7E);
`endif
    check("reset_floor", int'(bus.current_floor), 0);
    cyc(1, 3'b100, 0, 2);
    cyc(1, 0, 0, 20);
    check("up_to_2", int'(bus.current_floor), 2);
    cyc(1, 0, 3'b001, 1);
    cyc(1, 0, 0, 20);
    check("down_to_0", int'(bus.current_floor), 0);
    cyc(1, 3'b010, 3'b100, 1);
    cyc(1, 0, 0, 30);
    check("stop_then_2", int'(bus.current_floor), 2);
    cyc(1, 0, 3'b100, 1);
    cyc(1, 0, 0, 6);
    check("same_floor", int'(bus.current_floor), 2);
    cyc(1, 0, 3'b001, 1);
    cyc(1, 0, 0, 20);
    cyc(1, 0, 3'b100, 1);
    cyc(1, 0, 0, 3);
    check("mid_move", int'(bus.elevator_moving), 1);
    cyc(0, 0, 0, 1);
    check("mid_reset_dir", int'(bus.direction), 0);
    check("mid_reset_pend", int'(dut.pending), 0);
    for (int k = 0; k < 1500; k++) begin
      bit [2:0] e = $urandom_range(0, 5) == 0 ? 3'($urandom_range(0, 7)) : 3'b000;
      bit [2:0] r = $urandom_range(0, 7) == 0 ? 3'($urandom_range(0, 7)) : 3'b000;
      bit rs = $urandom_range(0, 200) != 0;
      cyc(rs, e, r, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
